// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline entry type and constants for datapath stage registers.
package pipe_pkg;
  localparam int PIPE_DATA_MAX = 64;
  typedef struct packed {
    logic                     valid;
    logic                     bubble;
    logic [PIPE_DATA_MAX-1:0] data;
  } pipe_entry_t;
  localparam pipe_entry_t PIPE_ZERO_ENTRY = '0;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + CNT_W'(1);
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with 2-entry skid, flush, stall and event counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_bubble_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_bubble_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);
  pipe_entry_t main_q, skid_q, main_d, skid_d, in_entry;
  logic in_fire, out_fire, take_main;
  assign in_ready_o   = !skid_q.valid && !stall_i && !flush_i;
  assign in_fire      = in_valid_i && in_ready_o;
  assign out_fire     = main_q.valid && out_ready_i && !stall_i;
  assign take_main    = !main_q.valid || out_fire;
  assign in_entry     = '{valid: 1'b1, bubble: in_bubble_i, data: PIPE_DATA_MAX'(in_data_i)};
  assign out_valid_o  = main_q.valid;
  assign out_data_o   = main_q.valid ? DATA_W'(main_q.data) : '0;
  assign out_bubble_o = main_q.valid && main_q.bubble;
  // Skid only ever fills while main is held, so it drains into main first to keep order.
  always_comb begin
    main_d = flush_i ? PIPE_ZERO_ENTRY : stall_i ? main_q :
             !take_main ? main_q : skid_q.valid ? skid_q : in_fire ? in_entry : PIPE_ZERO_ENTRY;
    skid_d = flush_i ? PIPE_ZERO_ENTRY : stall_i ? skid_q :
             take_main ? PIPE_ZERO_ENTRY : in_fire ? in_entry : skid_q;
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      main_q <= PIPE_ZERO_ENTRY;
      skid_q <= PIPE_ZERO_ENTRY;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (stall_i && !flush_i),
    .clear (1'b0),
    .cnt   (stall_cnt_o)
  );
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (flush_i),
    .clear (1'b0),
    .cnt   (flush_cnt_o)
  );
endmodule
